pwm_bank: RTL and testbench

- Parametrised multi-channel PWM generator.
- Successor to the single-timebase onboarding PWM peripheral.
- Written through a simple register port by the SPI register decoder. Drives up to NUM_CH output pins on uo_out/uio_out.
- New over the previous generation: programmable period (TOP) and prescaler, edge- or centre-aligned counting, shadowed duty/timing registers that update glitch-free at period boundaries, and registered readback.

---
 rtl/pwm_bank_pkg.sv | 44 ++++
 rtl/pwm_timebase.sv | 91 +++++++++
 rtl/pwm_bank.sv | 135 +++++++++++++
 tb/tb_pwm_bank.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_bank_pkg.sv
// Shared constants for the PWM bank: register offsets, CTRL bit positions,
// reset values and the counter direction type.
package pwm_bank_pkg;

    localparam int CTRL_CENTER = 0;
    localparam int CTRL_RUN    = 1;

    // Reset values. Width-agnostic constants are sized down by the user.
    localparam logic [31:0] DUTY_RST   = 32'h0000_0000;
    localparam logic [31:0] TOP_RST    = 32'hFFFF_FFFF;
    localparam logic [31:0] PRESC_RST  = 32'h0000_0000;
    localparam logic        CENTER_RST = 1'b0;
    localparam logic        RUN_RST    = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic int off_duty(input int ch);
        return ch;
    endfunction

    function automatic int off_out_en(input int num_ch);
        return num_ch;
    endfunction

    function automatic int off_pwm_en(input int num_ch);
        return num_ch + 1;
    endfunction

    function automatic int off_top(input int num_ch);
        return num_ch + 2;
    endfunction

    function automatic int off_presc(input int num_ch);
        return num_ch + 3;
    endfunction

    function automatic int off_ctrl(input int num_ch);
        return num_ch + 4;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, edge/centre up-down counter and the
// period boundary pulse. TOP/PRESC/CENTER are latched at period boundaries.
module pwm_timebase
    import pwm_bank_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic [CNT_W-1:0] top_i,
    input  logic [CNT_W-1:0] presc_i,
    input  logic             center_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             period_start_o
);

    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    logic [CNT_W-1:0] top_q, presc_q;
    logic             center_q;
    logic             tick, wrap, load;

    assign tick   = (pcnt_q >= presc_q);
    assign pcnt_d = tick ? '0 : pcnt_q + 1'b1;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        wrap  = 1'b0;
        if (tick) begin
            if (top_q == '0) begin
                cnt_d = '0;
                dir_d = DIR_UP;
                wrap  = 1'b1;
            end else if (!center_q) begin
                dir_d = DIR_UP;
                if (cnt_q >= top_q) begin
                    cnt_d = '0;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (dir_q == DIR_UP && cnt_q < top_q) begin
                cnt_d = cnt_q + 1'b1;
            end else if (cnt_q <= CNT_W'(1)) begin
                // Returning to 0 from 1 closes a centre-aligned period.
                cnt_d = '0;
                dir_d = DIR_UP;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
                dir_d = DIR_DOWN;
            end
        end
    end

    assign period_start_o = run_i & wrap;
    assign load           = period_start_o | ~run_i;
    assign cnt_o          = cnt_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q   <= '0;
            cnt_q    <= '0;
            dir_q    <= DIR_UP;
            top_q    <= CNT_W'(TOP_RST);
            presc_q  <= CNT_W'(PRESC_RST);
            center_q <= CENTER_RST;
        end else begin
            if (load) begin
                top_q    <= top_i;
                presc_q  <= presc_i;
                center_q <= center_i;
            end
            if (!run_i) begin
                pcnt_q <= '0;
                cnt_q  <= '0;
                dir_q  <= DIR_UP;
            end else begin
                pcnt_q <= pcnt_d;
                cnt_q  <= cnt_d;
                dir_q  <= dir_d;
            end
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: register file with shadowed timing/duty registers,
// per-channel compare and registered outputs, driven by one shared timebase.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    localparam logic [ADDR_W-1:0] A_OUT_EN = ADDR_W'(off_out_en(NUM_CH));
    localparam logic [ADDR_W-1:0] A_PWM_EN = ADDR_W'(off_pwm_en(NUM_CH));
    localparam logic [ADDR_W-1:0] A_TOP    = ADDR_W'(off_top(NUM_CH));
    localparam logic [ADDR_W-1:0] A_PRESC  = ADDR_W'(off_presc(NUM_CH));
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(off_ctrl(NUM_CH));

    logic [CNT_W-1:0]  duty_sh_q  [NUM_CH];
    logic [CNT_W-1:0]  duty_sh_d  [NUM_CH];
    logic [CNT_W-1:0]  duty_act_q [NUM_CH];
    logic [NUM_CH-1:0] out_en_q, out_en_d;
    logic [NUM_CH-1:0] pwm_en_q, pwm_en_d;
    logic [CNT_W-1:0]  top_sh_q, top_sh_d;
    logic [CNT_W-1:0]  presc_sh_q, presc_sh_d;
    logic              center_sh_q, center_sh_d;
    logic              run_q, run_d;
    logic [CNT_W-1:0]  rd_data_q, rd_mux;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [CNT_W-1:0]  cnt;
    logic              load;

    pwm_timebase #(.CNT_W(CNT_W)) u_timebase (
        .clk            (clk),
        .rst            (rst),
        .run_i          (run_q),
        .top_i          (top_sh_q),
        .presc_i        (presc_sh_q),
        .center_i       (center_sh_q),
        .cnt_o          (cnt),
        .period_start_o (period_start)
    );

    assign load = period_start | ~run_q;

    always_comb begin
        duty_sh_d   = duty_sh_q;
        out_en_d    = out_en_q;
        pwm_en_d    = pwm_en_q;
        top_sh_d    = top_sh_q;
        presc_sh_d  = presc_sh_q;
        center_sh_d = center_sh_q;
        run_d       = run_q;
        if (wr_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_addr == ADDR_W'(off_duty(i))) duty_sh_d[i] = wr_data;
            end
            case (wr_addr)
                A_OUT_EN: out_en_d = wr_data[NUM_CH-1:0];
                A_PWM_EN: pwm_en_d = wr_data[NUM_CH-1:0];
                A_TOP:    top_sh_d = wr_data;
                A_PRESC:  presc_sh_d = wr_data;
                A_CTRL: begin
                    center_sh_d = wr_data[CTRL_CENTER];
                    run_d       = wr_data[CTRL_RUN];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr == ADDR_W'(off_duty(i))) rd_mux = duty_sh_q[i];
        end
        case (rd_addr)
            A_OUT_EN: rd_mux = CNT_W'(out_en_q);
            A_PWM_EN: rd_mux = CNT_W'(pwm_en_q);
            A_TOP:    rd_mux = top_sh_q;
            A_PRESC:  rd_mux = presc_sh_q;
            A_CTRL:   rd_mux = CNT_W'({run_q, center_sh_q});
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = out_en_q[i] & (~pwm_en_q[i] | (cnt < duty_act_q[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the duty arrays are plain flops with defined reset values, not RAM, so they are reset.
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i]  <= CNT_W'(DUTY_RST);
                duty_act_q[i] <= CNT_W'(DUTY_RST);
            end
            out_en_q    <= '0;
            pwm_en_q    <= '0;
            top_sh_q    <= CNT_W'(TOP_RST);
            presc_sh_q  <= CNT_W'(PRESC_RST);
            center_sh_q <= CENTER_RST;
            run_q       <= RUN_RST;
            rd_data_q   <= '0;
            pwm_q       <= '0;
        end else begin
            duty_sh_q   <= duty_sh_d;
            out_en_q    <= out_en_d;
            pwm_en_q    <= pwm_en_d;
            top_sh_q    <= top_sh_d;
            presc_sh_q  <= presc_sh_d;
            center_sh_q <= center_sh_d;
            run_q       <= run_d;
            // Loading from the _q shadow means a write on a load cycle waits one more period.
            if (load) duty_act_q <= duty_sh_q;
            if (rd_en) rd_data_q <= rd_mux;
            pwm_q <= pwm_d;
        end
    end

    assign rd_data = rd_data_q;
    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank: stimulus queues expected reads and
// per-cycle {period_start, pwm_out}; a negedge monitor pops and compares.
module tb_pwm_bank;

    localparam logic [3:0] A_OUT_EN = 4'd8;
    localparam logic [3:0] A_PWM_EN = 4'd9;
    localparam logic [3:0] A_TOP    = 4'd10;
    localparam logic [3:0] A_PRESC  = 4'd11;
    localparam logic [3:0] A_CTRL   = 4'd12;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [7:0] pwm_out;
    logic       period_start;

    exp_t rd_q[$];
    exp_t wv_q[$];
    logic rd_vld_q = 1'b0;
    logic mon_en = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    pwm_bank #(.NUM_CH(8), .CNT_W(8), .ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_vld_q <= rd_en;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rd_vld_q) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got 0x%0h, want no read", rd_data);
            end else begin
                e = rd_q.pop_front();
                check(e.name, {8'd0, rd_data}, e.val);
            end
        end
        if (mon_en) begin
            if (wv_q.size() == 0) begin
                n_checks++;
                $display("FAIL wave_unexpected: got 0x%0h, want no sample", {period_start, pwm_out});
            end else begin
                e = wv_q.pop_front();
                check(e.name, {7'd0, period_start, pwm_out}, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
        rd_en = 1'b1; rd_addr = a;
        rd_q.push_back('{name, {8'd0, exp}});
        step();
        rd_en = 1'b0;
    endtask

    task automatic wr_rd(input logic [3:0] a, input logic [7:0] d, input logic [7:0] exp_old);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        rd_en = 1'b1; rd_addr = a;
        rd_q.push_back('{"rd_wr_same_addr", {8'd0, exp_old}});
        step();
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic push_wave(input string name, input logic ps, input logic [7:0] pwm);
        wv_q.push_back('{name, {7'd0, ps, pwm}});
    endtask

    task automatic window(input int n);
        mon_en = 1'b1;
        repeat (n) step();
        mon_en = 1'b0;
    endtask

    // Edge mode, TOP=9, PRESC=0: count during cycle k after run start.
    function automatic int edge_cnt(input int k);
        return (k == 0) ? 0 : (k - 1) % 10;
    endfunction

    // Centre mode, TOP=4, PRESC=1: each count lasts two clocks.
    function automatic int ctr_cnt(input int k);
        int tbl [8];
        tbl = '{0, 1, 2, 3, 4, 3, 2, 1};
        return (k == 0) ? 0 : tbl[((k - 1) / 2) % 8];
    endfunction

    // Active DUTY0 in the shadowing run: writes land in cycles 5 and 20.
    function automatic int shadow_duty(input int k);
        if (k <= 10) return 3;
        if (k <= 30) return 7;
        return 2;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset defaults
        for (int i = 0; i < 4; i++) push_wave($sformatf("reset_out%0d", i), 1'b0, 8'h00);
        window(4);
        for (int a = 0; a < 8; a++) rd(4'(a), 8'h00, $sformatf("rst_duty%0d", a));
        rd(A_OUT_EN, 8'h00, "rst_out_en");
        rd(A_PWM_EN, 8'h00, "rst_pwm_en");
        rd(A_TOP,    8'hFF, "rst_top");
        rd(A_PRESC,  8'h00, "rst_presc");
        rd(A_CTRL,   8'h02, "rst_ctrl");
        rd(4'd13,    8'h00, "unmapped_rd");
        wr(4'd15, 8'hFF);
        rd(4'd15,    8'h00, "unmapped_wr_rd");
        rd(A_TOP,    8'hFF, "unmapped_wr_top");

        // Edge PWM setup while stopped, then shadowed duty updates
        wr(A_CTRL, 8'h00);
        wr_rd(4'd0, 8'd3, 8'h00);
        rd(4'd0, 8'd3, "duty0_write");
        wr(A_TOP, 8'd9);
        wr(A_PRESC, 8'd0);
        wr(A_OUT_EN, 8'h01);
        wr(A_PWM_EN, 8'h01);
        rd(A_TOP, 8'd9, "top_write");
        rd(A_CTRL, 8'h00, "ctrl_stopped");
        for (int i = 0; i < 4; i++) push_wave($sformatf("stopped%0d", i), 1'b0, 8'h01);
        window(4);
        for (int k = 1; k <= 40; k++)
            push_wave($sformatf("edge_shadow_k%0d", k), (k % 10) == 0,
                      {7'd0, edge_cnt(k - 1) < shadow_duty(k - 1)});
        wr(A_CTRL, 8'h02);
        mon_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) wr(4'd0, 8'd7);
            else if (k == 20) wr(4'd0, 8'd2);
            else step();
        end
        mon_en = 1'b0;
        rd(4'd0, 8'd2, "duty0_shadow_rd");

        // Static and limit cases
        wr(A_CTRL, 8'h00);
        wr(4'd1, 8'd0);
        wr(4'd2, 8'd10);
        wr(4'd3, 8'd5);
        wr(A_OUT_EN, 8'h07);
        wr(A_PWM_EN, 8'h0E);
        for (int k = 1; k <= 25; k++)
            push_wave($sformatf("static_k%0d", k), (k % 10) == 0, 8'h05);
        wr(A_CTRL, 8'h02);
        window(25);

        // Prescaler and centre mode
        wr(A_CTRL, 8'h01);
        wr(A_TOP, 8'd4);
        wr(A_PRESC, 8'd1);
        wr(4'd1, 8'd2);
        wr(A_OUT_EN, 8'h02);
        wr(A_PWM_EN, 8'h02);
        rd(A_CTRL, 8'h01, "ctrl_center");
        rd(A_PRESC, 8'h01, "presc_write");
        for (int k = 1; k <= 34; k++)
            push_wave($sformatf("centre_k%0d", k), (k % 16) == 0,
                      (ctr_cnt(k - 1) < 2) ? 8'h02 : 8'h00);
        wr(A_CTRL, 8'h03);
        window(34);

        // TOP = 0: no pulses while stopped, a pulse every tick once running
        wr(A_CTRL, 8'h00);
        wr(A_TOP, 8'd0);
        wr(A_PRESC, 8'd0);
        wr(A_OUT_EN, 8'h00);
        rd(A_TOP, 8'h00, "top_zero");
        for (int i = 0; i < 3; i++) push_wave($sformatf("top0_stopped%0d", i), 1'b0, 8'h00);
        window(3);
        for (int k = 1; k <= 6; k++) push_wave($sformatf("top0_run_k%0d", k), 1'b1, 8'h00);
        wr(A_CTRL, 8'h02);
        window(6);

        // Reset mid-operation
        wr(A_OUT_EN, 8'h01);
        wr(A_PWM_EN, 8'h00);
        step();
        step();
        push_wave("pre_reset", 1'b1, 8'h01);
        for (int i = 0; i < 3; i++) push_wave($sformatf("post_reset%0d", i), 1'b0, 8'h00);
        rst = 1'b1;
        mon_en = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        mon_en = 1'b0;
        rd(4'd1,     8'h00, "rst2_duty1");
        rd(4'd2,     8'h00, "rst2_duty2");
        rd(A_OUT_EN, 8'h00, "rst2_out_en");
        rd(A_PWM_EN, 8'h00, "rst2_pwm_en");
        rd(A_TOP,    8'hFF, "rst2_top");
        rd(A_PRESC,  8'h00, "rst2_presc");
        rd(A_CTRL,   8'h02, "rst2_ctrl");

        repeat (3) step();
        if (rd_q.size() != 0 || wv_q.size() != 0) begin
            n_checks++;
            $display("FAIL leftover: got %0d reads %0d samples pending, want 0",
                     rd_q.size(), wv_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
